i2c_master_arbiter: RTL and testbench
=====================================

I2C_MASTER_ARBITER -- requirements
Module: i2c_master_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT, 4095, max clk cycles spent in any single wait state before abort.
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports: req0/req1  input  1  transaction request from requester 0/1, level, held until done.
REQ-005 SHALL have ports: rw0/rw1  input  1  per-requester direction (1 = read).
REQ-006 SHALL have ports: addr0/addr1  input  7  per-requester slave address.
REQ-007 SHALL have ports: wdata0/wdata1  input  8  per-requester write byte.
REQ-008 SHALL have ports: done0/done1  output  1  one-cycle completion pulse to requester 0/1.
REQ-009 SHALL have ports: err0/err1  output  1  valid with done; 1 = nack or timeout.
REQ-010 SHALL have port: rdata  output  8  read byte, valid with done of a read.
REQ-011 SHALL have ports to i2c_master: m_enable, m_rw, m_address[6:0], m_txdata[7:0] outputs; m_ready, m_ack, m_nack, m_rxdata[7:0] inputs.

Function
REQ-012 SHALL implement states IDLE, ARB, START, ADDR, DATA, STOP, DONE.
REQ-013 IDLE: when m_ready=1 and any req set, go to ARB next cycle.
REQ-014 ARB: grant by round-robin; last_grant flag starts at 1, so requester 0 wins the first contention; a sole requester always wins; last_grant updates to the winner.
REQ-015 ARB: latch the winner's rw/addr/wdata into internal registers; later changes to the request inputs SHALL NOT affect the current transaction.
REQ-016 START: drive m_enable=1 with the latched m_rw/m_address/m_txdata; go to ADDR when m_ready falls.
REQ-017 ADDR: wait for the first m_ack rising edge (edge-detect with 1-cycle registered copy), then go to DATA.
REQ-018 DATA: on the second m_ack rising edge, capture m_rxdata into the rdata register when a read, then go to STOP.
REQ-019 START/ADDR/DATA: if m_nack=1, set the error flag and go to STOP immediately.
REQ-020 STOP: drive m_enable=0; go to DONE when m_ready=1.
REQ-021 DONE: pulse the granted done_x for exactly one cycle with err_x; return to IDLE.
REQ-022 Timeout: a counter clears on every state change and increments otherwise; when it reaches TIMEOUT in START/ADDR/DATA, set err and go to STOP; in STOP, force DONE with err=1.
REQ-023 m_enable SHALL be 1 only in START/ADDR/DATA; m_rw/m_address/m_txdata SHALL hold latched values from ARB until the next ARB.
REQ-024 Dropping the granted req mid-transaction SHALL NOT abort it; done still pulses.
REQ-025 The non-granted requester SHALL wait; its done/err stay 0.
REQ-026 m_ack edges seen in STOP/DONE/IDLE SHALL be ignored.
REQ-027 rdata SHALL hold its value until the next read completes; on write or error it SHALL be unchanged.

Reset
REQ-028 On reset_n=0 at clk edge: state=IDLE, m_enable=0, m_rw=0, m_address=0, m_txdata=0, done0/1=0, err0/1=0, rdata=0, timeout counter=0, last_grant=1, ack edge register=0.
REQ-029 Reset mid-transaction SHALL drop m_enable in the same edge and SHALL NOT generate any done pulse.

Verification
REQ-030 Single write: req0=1, rw0=0, addr0=0x50, wdata0=0xFE; slave acks -> m_address=0x50, m_txdata=0xFE, done0 one pulse, err0=0.
REQ-031 Single read: req1=1, rw1=1, addr1=0x51; slave returns 0xBB -> rdata=0xBB at done1, err1=0.
REQ-032 Contention: req0 and req1 raised on the same cycle and held -> transaction 0 first, then 1; next simultaneous pair -> 0 before 1 (last_grant was 1).
REQ-033 NACK: addr0=0x33, no such slave -> m_nack observed, m_enable drops, done0 with err0=1, rdata unchanged.
REQ-034 Timeout: TIMEOUT=15, master ready held low with no ack -> err=1 done after about 16 cycles in ADDR plus STOP handling.
REQ-035 Reset in DATA phase -> next cycle m_enable=0, state IDLE, no done pulse; a fresh req0 then completes normally.

Source files
------------

// File: rtl/i2c_master_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_master_arbiter
// Shares a single byte-level i2c_master between two requesters. Each
// transaction moves one address phase and one data byte. Requests are
// level-held; a one-cycle done pulse (with err) closes each transaction.
//
// Ports
//   clk, reset_n                  clock, synchronous active-low reset
//   req0/1, rw0/1, addr0/1,       per-requester request, direction (1=read),
//   wdata0/1                      7-bit slave address and write byte
//   done0/1, err0/1               completion pulse and error (nack/timeout)
//   rdata                         last successfully read byte
//   m_enable, m_rw, m_address,    command to the i2c_master
//   m_txdata
//   m_ready, m_ack, m_nack,       status from the i2c_master
//   m_rxdata
// -----------------------------------------------------------------------------
module i2c_master_arbiter #(
  parameter int TIMEOUT = 4095
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       rw0,
  input  logic       rw1,
  input  logic [6:0] addr0,
  input  logic [6:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       done0,
  output logic       done1,
  output logic       err0,
  output logic       err1,
  output logic [7:0] rdata,
  output logic       m_enable,
  output logic       m_rw,
  output logic [6:0] m_address,
  output logic [7:0] m_txdata,
  input  logic       m_ready,
  input  logic       m_ack,
  input  logic       m_nack,
  input  logic [7:0] m_rxdata
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    START,
    ADDR,
    DATA,
    STOP,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             last_grant;
  logic             grant;
  logic             grant_next;
  logic             err_flag;
  logic             err_next;
  logic             ack_q;
  logic             ack_rise;
  logic             latch_req;
  logic             rdata_load;

  assign tmo_hit  = (tmo_cnt == CNT_W'(TIMEOUT));
  // Only a fresh low-to-high transition of m_ack counts as an acknowledge.
  assign ack_rise = m_ack & ~ack_q;

  always_comb begin
    state_next = state;
    grant_next = grant;
    err_next   = err_flag;
    latch_req  = 1'b0;
    rdata_load = 1'b0;
    case (state)
      IDLE: begin
        if (m_ready && (req0 || req1)) state_next = ARB;
      end
      ARB: begin
        if (req0 || req1) begin
          // On contention the requester that did not win last time goes.
          grant_next = (req0 && req1) ? ~last_grant : req1;
          latch_req  = 1'b1;
          err_next   = 1'b0;
          state_next = START;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        if (m_nack) begin
          err_next   = 1'b1;
          state_next = STOP;
        end else if (!m_ready) begin
          state_next = ADDR;
        end else if (tmo_hit) begin
          err_next   = 1'b1;
          state_next = STOP;
        end
      end
      ADDR: begin
        if (m_nack) begin
          err_next   = 1'b1;
          state_next = STOP;
        end else if (ack_rise) begin
          state_next = DATA;
        end else if (tmo_hit) begin
          err_next   = 1'b1;
          state_next = STOP;
        end
      end
      DATA: begin
        if (m_nack) begin
          err_next   = 1'b1;
          state_next = STOP;
        end else if (ack_rise) begin
          rdata_load = m_rw;
          state_next = STOP;
        end else if (tmo_hit) begin
          err_next   = 1'b1;
          state_next = STOP;
        end
      end
      STOP: begin
        if (m_ready) begin
          state_next = DONE;
        end else if (tmo_hit) begin
          // The master never came back; close the transaction as failed.
          err_next   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      err_flag   <= 1'b0;
      ack_q      <= 1'b0;
      m_rw       <= 1'b0;
      m_address  <= '0;
      m_txdata   <= '0;
      rdata      <= '0;
    end else begin
      state    <= state_next;
      grant    <= grant_next;
      err_flag <= err_next;
      ack_q    <= m_ack;
      // Counter measures time spent in the current state; it saturates so
      // long idle periods cannot wrap it.
      if (state_next != state) tmo_cnt <= '0;
      else if (!tmo_hit)       tmo_cnt <= tmo_cnt + 1'b1;
      if (latch_req) begin
        last_grant <= grant_next;
        m_rw       <= grant_next ? rw1    : rw0;
        m_address  <= grant_next ? addr1  : addr0;
        m_txdata   <= grant_next ? wdata1 : wdata0;
      end
      if (rdata_load) rdata <= m_rxdata;
    end
  end

  // Decoded from state so a reset removes the enable on the same edge.
  assign m_enable = (state == START) || (state == ADDR) || (state == DATA);
  assign done0    = (state == DONE) && !grant;
  assign done1    = (state == DONE) &&  grant;
  assign err0     = done0 && err_flag;
  assign err1     = done1 && err_flag;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
module tb_i2c_master_arbiter;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req0_v = 1'b0, req1_v = 1'b0, rw0_v = 1'b0, rw1_v = 1'b0;
  logic [6:0] addr0_v = '0, addr1_v = '0;
  logic [7:0] wdata0_v = '0, wdata1_v = '0;
  logic       done0, done1, err0, err1;
  logic [7:0] rdata;
  logic       m_enable, m_rw;
  logic [6:0] m_address;
  logic [7:0] m_txdata;
  logic       m_ready = 1'b1, m_ack = 1'b0, m_nack = 1'b0;
  logic [7:0] m_rxdata = '0;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int         who;
    bit         err;
    bit         rd;
    logic [7:0] rx;
  } exp_t;

  exp_t expq[$];
  int   done_log[$];
  int   force_mode = 0;
  int   force_rx = -1;
  int   rst_cnt = 0;
  int   grant_cnt0 = 0, grant_cnt1 = 0;
  logic cur_rw = 1'b0;
  logic [6:0] cur_addr = '0;
  logic [7:0] cur_tx = '0;
  logic last_grant_m = 1'b1;

  // Request inputs as seen by the DUT at each rising edge.
  logic a_req0 = 0, a_req1 = 0, a_rw0 = 0, a_rw1 = 0;
  logic [6:0] a_addr0 = '0, a_addr1 = '0;
  logic [7:0] a_wd0 = '0, a_wd1 = '0;

  i2c_master_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0_v), .req1(req1_v), .rw0(rw0_v), .rw1(rw1_v),
    .addr0(addr0_v), .addr1(addr1_v), .wdata0(wdata0_v), .wdata1(wdata1_v),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1), .rdata(rdata),
    .m_enable(m_enable), .m_rw(m_rw), .m_address(m_address), .m_txdata(m_txdata),
    .m_ready(m_ready), .m_ack(m_ack), .m_nack(m_nack), .m_rxdata(m_rxdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    a_req0 <= req0_v; a_req1 <= req1_v; a_rw0 <= rw0_v; a_rw1 <= rw1_v;
    a_addr0 <= addr0_v; a_addr1 <= addr1_v; a_wd0 <= wdata0_v; a_wd1 <= wdata1_v;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_en_low(input string name);
    for (int i = 0; i < 200 && m_enable; i++) @(negedge clk);
    chk(name, {31'd0, m_enable}, 32'd0);
  endtask

  task automatic ack_pulse();
    m_ack = 1'b1;
    @(negedge clk);
    m_ack = 1'b0;
  endtask

  // Slave / bus model: reacts to each transaction start, predicts its outcome.
  initial begin : slave
    exp_t e;
    int   mode, who, cnt;
    logic exp_rw;
    logic [6:0] exp_a;
    logic [7:0] exp_w;
    @(negedge clk);
    forever begin
      while (!m_enable) @(negedge clk);
      // Arbitration decided on the inputs present at the edge just passed.
      if (a_req0 && a_req1) who = last_grant_m ? 0 : 1;
      else                  who = a_req0 ? 0 : 1;
      last_grant_m = who[0];
      exp_rw = who ? a_rw1 : a_rw0;
      exp_a  = who ? a_addr1 : a_addr0;
      exp_w  = who ? a_wd1 : a_wd0;
      chk("grant_cmd", {15'd0, m_rw, m_address, m_txdata}, {15'd0, exp_rw, exp_a, exp_w});
      cur_rw = exp_rw; cur_addr = exp_a; cur_tx = exp_w;
      if (who == 0) grant_cnt0++; else grant_cnt1++;
      if (force_mode >= 0) mode = force_mode;
      else begin
        cnt  = $urandom_range(0, 9);
        mode = (cnt < 6) ? 0 : (cnt < 8) ? 1 : 2;
      end
      e.who = who; e.rd = exp_rw;
      e.rx  = (force_rx >= 0) ? force_rx[7:0] : 8'($urandom);
      e.err = (mode != 0);
      expq.push_back(e);
      case (mode)
        0: begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          m_ready = 1'b0;
          repeat (1 + $urandom_range(0, 3)) @(negedge clk);
          ack_pulse();
          m_rxdata = e.rx;
          repeat (1 + $urandom_range(0, 3)) @(negedge clk);
          ack_pulse();
          m_rxdata = 8'($urandom);
          wait_en_low("ok_enable_drop");
          repeat ($urandom_range(0, 3)) @(negedge clk);
          m_ready = 1'b1;
          if ($urandom_range(0, 1) == 1) begin
            @(negedge clk);
            ack_pulse();
          end
        end
        1: begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          m_ready = 1'b0;
          if ($urandom_range(0, 1) == 1) begin
            repeat (1 + $urandom_range(0, 2)) @(negedge clk);
            ack_pulse();
          end
          m_rxdata = e.rx;
          repeat (1 + $urandom_range(0, 3)) @(negedge clk);
          m_nack = 1'b1;
          wait_en_low("nack_enable_drop");
          m_nack = 1'b0;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          m_ready = 1'b1;
        end
        2: begin
          m_ready = 1'b0;
          cnt = 0;
          while (m_enable && cnt < 100) begin
            cnt++;
            @(negedge clk);
          end
          // one START cycle plus TIMEOUT+1 cycles waiting in ADDR
          chk("hang_enable_len", cnt, TMO + 2);
          if ($urandom_range(0, 1) == 1) repeat (TMO + 6) @(negedge clk);
          else repeat (2) @(negedge clk);
          m_ready = 1'b1;
        end
        default: begin
          m_ready = 1'b0;
          @(negedge clk);
          ack_pulse();
          @(negedge clk);
          reset_n = 1'b0;
          cur_rw = 1'b0; cur_addr = '0; cur_tx = '0;
          last_grant_m = 1'b1;
          void'(expq.pop_back());
          @(negedge clk);
          chk("reset_enable_drop", {31'd0, m_enable}, 32'd0);
          reset_n = 1'b1;
          rst_cnt++;
          repeat (4) @(negedge clk);
          m_ready = 1'b1;
        end
      endcase
    end
  end

  // Compare process: command stability every cycle, outcome on every done.
  initial begin : compare
    logic en_prev;
    logic [7:0] model_rdata;
    exp_t e;
    en_prev = 1'b0;
    model_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) model_rdata = '0;
      if (reset_n && !(m_enable && !en_prev))
        chk("cmd_hold", {15'd0, m_rw, m_address, m_txdata}, {15'd0, cur_rw, cur_addr, cur_tx});
      if (done0 || done1) begin
        if (expq.size() == 0) begin
          chk("unexpected_done", {30'd0, done1, done0}, 32'd0);
        end else begin
          e = expq.pop_front();
          if (e.rd && !e.err) model_rdata = e.rx;
          done_log.push_back(done1 ? 1 : 0);
          chk("done_who", {30'd0, done1, done0}, e.who ? 32'd2 : 32'd1);
          chk("done_err", {30'd0, err1, err0}, e.err ? (e.who ? 32'd2 : 32'd1) : 32'd0);
          chk("rdata", {24'd0, rdata}, {24'd0, model_rdata});
        end
      end
      en_prev = m_enable;
    end
  end

  task automatic do_txn(input int who, input logic rw, input logic [6:0] a,
                        input logic [7:0] w, input bit drop_early,
                        output logic [6:0] o_addr, output logic [7:0] o_tx,
                        output logic [7:0] o_rd, output logic o_err);
    int  t, g0;
    bit  got, scr;
    got = 0; scr = 0;
    g0 = (who == 0) ? grant_cnt0 : grant_cnt1;
    if (who == 0) begin rw0_v = rw; addr0_v = a; wdata0_v = w; req0_v = 1'b1; end
    else          begin rw1_v = rw; addr1_v = a; wdata1_v = w; req1_v = 1'b1; end
    t = 0;
    while (t < 600) begin
      @(negedge clk);
      t++;
      if (!scr && g0 != ((who == 0) ? grant_cnt0 : grant_cnt1)) begin
        // granted: change the inputs, the running transaction must not care
        scr = 1;
        if (who == 0) begin rw0_v = ~rw0_v; addr0_v = 7'($urandom); wdata0_v = 8'($urandom); end
        else          begin rw1_v = ~rw1_v; addr1_v = 7'($urandom); wdata1_v = 8'($urandom); end
        if (drop_early) begin
          if (who == 0) req0_v = 1'b0; else req1_v = 1'b0;
        end
      end
      if ((who == 0) ? done0 : done1) begin
        got = 1;
        break;
      end
    end
    chk("txn_completed", {31'd0, got}, 32'd1);
    o_addr = m_address; o_tx = m_txdata; o_rd = rdata;
    o_err = (who == 0) ? err0 : err1;
    if (who == 0) req0_v = 1'b0; else req1_v = 1'b0;
    @(negedge clk);
  endtask

  task automatic rand_requester(input int who, input int n);
    logic [6:0] oa; logic [7:0] ot, ord; logic oe;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      do_txn(who, 1'($urandom), 7'($urandom), 8'($urandom), 0, oa, ot, ord, oe);
    end
  endtask

  initial begin : main
    logic [6:0] oa; logic [7:0] ot, ord; logic oe;
    int n0, t;
    repeat (3) @(negedge clk);
    chk("reset_done_err", {28'd0, done1, done0, err1, err0}, 32'd0);
    chk("reset_enable", {31'd0, m_enable}, 32'd0);
    chk("reset_cmd", {15'd0, m_rw, m_address, m_txdata}, 32'd0);
    chk("reset_rdata", {24'd0, rdata}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    force_mode = 0;
    do_txn(0, 1'b0, 7'h50, 8'hFE, 0, oa, ot, ord, oe);
    chk("write_addr", {25'd0, oa}, 32'h50);
    chk("write_data", {24'd0, ot}, 32'hFE);
    chk("write_err", {31'd0, oe}, 32'd0);

    force_rx = 8'hBB;
    do_txn(1, 1'b1, 7'h51, 8'h00, 0, oa, ot, ord, oe);
    chk("read_rdata", {24'd0, ord}, 32'hBB);
    chk("read_err", {31'd0, oe}, 32'd0);
    force_rx = -1;

    for (int p = 0; p < 2; p++) begin
      n0 = done_log.size();
      fork
        begin
          logic [6:0] a0; logic [7:0] t0, r0; logic e0;
          do_txn(0, 1'b0, 7'h10, 8'h01, 0, a0, t0, r0, e0);
        end
        begin
          logic [6:0] a1; logic [7:0] t1, r1; logic e1;
          do_txn(1, 1'b0, 7'h20, 8'h02, 0, a1, t1, r1, e1);
        end
      join
      repeat (2) @(negedge clk);
      t = (done_log.size() >= n0 + 2) ? done_log[n0] * 2 + done_log[n0 + 1] : -1;
      chk("contention_order", t, 32'd1);
    end

    force_mode = 1;
    do_txn(0, 1'b0, 7'h33, 8'h12, 0, oa, ot, ord, oe);
    chk("nack_err", {31'd0, oe}, 32'd1);
    chk("nack_rdata_kept", {24'd0, ord}, 32'hBB);

    force_mode = 2;
    do_txn(1, 1'b1, 7'h44, 8'h00, 0, oa, ot, ord, oe);
    chk("timeout_err", {31'd0, oe}, 32'd1);
    chk("timeout_rdata_kept", {24'd0, ord}, 32'hBB);

    force_mode = 0;
    do_txn(0, 1'b0, 7'h0A, 8'h5C, 1, oa, ot, ord, oe);
    chk("drop_req_err", {31'd0, oe}, 32'd0);

    force_mode = 3;
    n0 = rst_cnt;
    rw0_v = 1'b1; addr0_v = 7'h22; req0_v = 1'b1;
    for (int i = 0; i < 300 && rst_cnt == n0; i++) @(negedge clk);
    req0_v = 1'b0;
    chk("reset_in_data_seen", rst_cnt, n0 + 1);
    repeat (6) @(negedge clk);
    chk("after_reset_rdata", {24'd0, rdata}, 32'd0);
    force_mode = 0;
    force_rx = 8'h5A;
    do_txn(0, 1'b1, 7'h22, 8'h00, 0, oa, ot, ord, oe);
    chk("after_reset_read", {24'd0, ord}, 32'h5A);
    force_rx = -1;

    force_mode = -1;
    fork
      rand_requester(0, 20);
      rand_requester(1, 20);
    join
    repeat (40) @(negedge clk);
    chk("queue_drained", expq.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
